// File: rtl/circle_path_sequencer_if.sv
// Control and position bundle between the circle-chase sequencer and its driver.
// slave = sequencer side, master = controller / consumer side.
interface circle_path_sequencer_if;
  logic       enable_i;
  logic       clear_i;
  logic       dir_i;
  logic [1:0] speed_i;
  logic [2:0] row_index_o;
  logic       column_index_o;
  logic [3:0] pos_o;
  logic       step_o;
  logic       lap_o;

  modport slave (
    input  enable_i, clear_i, dir_i, speed_i,
    output row_index_o, column_index_o, pos_o, step_o, lap_o
  );

  modport master (
    output enable_i, clear_i, dir_i, speed_i,
    input  row_index_o, column_index_o, pos_o, step_o, lap_o
  );
endinterface

// File: rtl/circle_path_sequencer.sv
// Walks one circle around the 12-step upper/lower loop of a 7-seg display row.
// Optional macro CIRCLE_SEQ_BOUNCE_EN: ping-pong between the loop ends instead of wrapping.
module circle_path_sequencer #(
  parameter int unsigned BASE_DIV   = 5_000_000,
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned START_POS  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  circle_path_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2((BASE_DIV << 3) + 1);
  localparam logic [3:0]  LAST_POS = 4'(2 * NUM_DIGITS - 1);
  localparam logic [3:0]  START_P  = 4'(START_POS);
  localparam logic [3:0]  NUM_D    = 4'(NUM_DIGITS);

  logic [CNT_W-1:0] cnt_q, cnt_d, limit_s;
  logic [3:0]       pos_q, pos_d;
  logic             step_q, step_d, lap_q, lap_d;
  logic             tick_s, dir_s, wrap_s;
  logic [2:0]       row_s;
  logic             col_s;

  // A speed change applies at once; an overshooting count ticks immediately.
  assign limit_s = (CNT_W'(BASE_DIV) << bus.speed_i) - CNT_W'(1);
  assign tick_s  = bus.enable_i && (cnt_q >= limit_s);

`ifdef CIRCLE_SEQ_BOUNCE_EN
  logic dir_q, dir_d, dir_vld_q, dir_vld_d;
  assign dir_s = dir_vld_q ? dir_q : bus.dir_i;
`else
  assign dir_s = bus.dir_i;
`endif

  // Next-state for prescaler, position and the step/lap pulses.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    wrap_s = 1'b0;
`ifdef CIRCLE_SEQ_BOUNCE_EN
    dir_d     = dir_q;
    dir_vld_d = dir_vld_q;
`endif
    if (bus.clear_i) begin
      cnt_d = '0;
      pos_d = START_P;
`ifdef CIRCLE_SEQ_BOUNCE_EN
      dir_d     = bus.dir_i;
      dir_vld_d = 1'b1;
`endif
    end else if (tick_s) begin
      cnt_d = '0;
`ifdef CIRCLE_SEQ_BOUNCE_EN
      dir_vld_d = 1'b1;
      dir_d     = dir_s;
      if (!dir_s && (pos_q == LAST_POS)) begin
        pos_d  = LAST_POS - 4'd1;
        dir_d  = 1'b1;
        wrap_s = 1'b1;
      end else if (dir_s && (pos_q == 4'd0)) begin
        pos_d  = 4'd1;
        dir_d  = 1'b0;
        wrap_s = 1'b1;
      end else if (!dir_s) begin
        pos_d = pos_q + 4'd1;
      end else begin
        pos_d = pos_q - 4'd1;
      end
`else
      if (!dir_s) begin
        wrap_s = (pos_q == LAST_POS);
        pos_d  = wrap_s ? 4'd0 : pos_q + 4'd1;
      end else begin
        wrap_s = (pos_q == 4'd0);
        pos_d  = wrap_s ? LAST_POS : pos_q - 4'd1;
      end
`endif
    end else if (bus.enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    step_d = tick_s && !bus.clear_i;
    lap_d  = step_d && wrap_s;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      pos_q  <= START_P;
      step_q <= 1'b0;
      lap_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      step_q <= step_d;
      lap_q  <= lap_d;
    end
  end

`ifdef CIRCLE_SEQ_BOUNCE_EN
  // Direction latch; unloaded until the first tick or clear after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q     <= 1'b0;
      dir_vld_q <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      dir_vld_q <= dir_vld_d;
    end
  end
`endif

  // Upper half counts digits up, lower half walks them back down.
  always_comb begin
    if (pos_q < NUM_D) begin
      row_s = pos_q[2:0];
      col_s = 1'b0;
    end else begin
      row_s = 3'(LAST_POS - pos_q);
      col_s = 1'b1;
    end
  end

  assign bus.row_index_o    = row_s;
  assign bus.column_index_o = col_s;
  assign bus.pos_o          = pos_q;
  assign bus.step_o         = step_q;
  assign bus.lap_o          = lap_q;

endmodule

// File: tb/tb_circle_path_sequencer.sv
// Directed bench for circle_path_sequencer (BASE_DIV=4): expected steps are queued
// with their cycle stamp and checked by a separate monitor on step_o.
module tb_circle_path_sequencer;

  typedef struct {
    int         cyc;
    logic [3:0] pos;
    logic [2:0] row;
    logic       col;
    logic       lap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [2:0] row_tab [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                               3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic       col_tab [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  circle_path_sequencer_if bus();

  circle_path_sequencer #(
    .BASE_DIV  (4),
    .NUM_DIGITS(6),
    .START_POS (0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int p, input bit lap);
    exp_t e;
    e.cyc = c;
    e.pos = 4'(p);
    e.row = row_tab[p];
    e.col = col_tab[p];
    e.lap = lap;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one expectation per step pulse, flags overdue and stray pulses.
  always @(negedge clk) begin
    if (rst_ni) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL step_missing actual=none required=pos %0d at cycle %0d", sb[0].pos, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.lap_o) chk("lap_with_step", {31'd0, bus.step_o}, 32'd1);
      if (bus.step_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_step actual=pos %0d at cycle %0d required=no step", bus.pos_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("step_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("pos", {28'd0, bus.pos_o}, {28'd0, mon_e.pos});
          chk("row", {29'd0, bus.row_index_o}, {29'd0, mon_e.row});
          chk("col", {31'd0, bus.column_index_o}, {31'd0, mon_e.col});
          chk("lap", {31'd0, bus.lap_o}, {31'd0, mon_e.lap});
        end
      end
    end
  end

  initial begin
    int n, m, p, q, r;
    rst_ni         = 1'b0;
    bus.enable_i   = 1'b0;
    bus.clear_i    = 1'b0;
    bus.dir_i      = 1'b0;
    bus.speed_i    = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pos", {28'd0, bus.pos_o}, 32'd0);
    chk("reset_row", {29'd0, bus.row_index_o}, 32'd0);
    chk("reset_col", {31'd0, bus.column_index_o}, 32'd0);
    chk("reset_step", {31'd0, bus.step_o}, 32'd0);
    chk("reset_lap", {31'd0, bus.lap_o}, 32'd0);

    rst_ni       = 1'b1;
    bus.enable_i = 1'b1;
    n = cyc;
`ifdef CIRCLE_SEQ_BOUNCE_EN
    // Up to 11, bounce down to 0, bounce back to 1; dir_i is ignored once latched.
    for (int k = 1; k <= 23; k++) begin
      if (k <= 11)      push(n + 4 * k, k, 1'b0);
      else if (k <= 22) push(n + 4 * k, 22 - k, k == 12);
      else              push(n + 4 * k, 1, 1'b1);
    end
    wait_until(n + 4);
    bus.dir_i = 1'b1;
    wait_until(n + 96);
`else
    // Forward lap: one step every 4 cycles, lap only on 11 -> 0.
    for (int k = 1; k <= 12; k++) push(n + 4 * k, k % 12, k == 12);
    wait_until(n + 48);

    // Reverse from 0 wraps to 11 with lap.
    bus.dir_i = 1'b1;
    push(n + 52, 11, 1'b1);
    push(n + 56, 10, 1'b0);
    push(n + 60, 9, 1'b0);
    wait_until(n + 60);

    // Speed 2 -> 0 with count already at 10: immediate tick.
    m = cyc;
    bus.dir_i   = 1'b0;
    bus.speed_i = 2'd2;
    push(m + 11, 10, 1'b0);
    push(m + 15, 11, 1'b0);
    wait_until(m + 10);
    bus.speed_i = 2'd0;
    wait_until(m + 15);

    // Freeze at count 2 for 20 cycles; resume needs 2 more cycles.
    p = cyc;
    wait_until(p + 2);
    bus.enable_i = 1'b0;
    wait_until(p + 12);
    chk("frozen_pos", {28'd0, bus.pos_o}, 32'd11);
    chk("frozen_step", {31'd0, bus.step_o}, 32'd0);
    wait_until(p + 22);
    bus.enable_i = 1'b1;
    push(p + 24, 0, 1'b1);
    wait_until(p + 24);

    // Clear collides with the tick leaving pos 5.
    q = cyc;
    for (int k = 1; k <= 5; k++) push(q + 4 * k, k, 1'b0);
    wait_until(q + 23);
    bus.clear_i = 1'b1;
    wait_until(q + 24);
    bus.clear_i = 1'b0;
    chk("clear_pos", {28'd0, bus.pos_o}, 32'd0);
    chk("clear_step", {31'd0, bus.step_o}, 32'd0);
    push(q + 28, 1, 1'b0);
    wait_until(q + 30);

    // Asynchronous reset mid-count; prescaler restarts from zero.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_pos", {28'd0, bus.pos_o}, 32'd0);
    chk("async_rst_step", {31'd0, bus.step_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    r = cyc;
    push(r + 4, 1, 1'b0);
    wait_until(r + 6);
`endif
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
